// File: rtl/kmeans_dist_unit.sv
`default_nettype none
// ============================================================================
// Module      : kmeans_dist_unit
// Description : Pipelined per-vector distance engine for the K-means datapath.
//               Streams DIM (x, y) element pairs, forms |x-y| (L1) or (x-y)^2
//               (squared L2) per element and accumulates one distance per
//               vector. Valid/ready handshakes on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module kmeans_dist_unit #(
  parameter int WIDTH = 32,
  parameter int DIM   = 4,
  parameter int ACC_W = 66
) (
  input  logic             minus_clk,
  input  logic             minus_rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_dist,
  output logic             out_mode
);

  localparam int c_cnt_w = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIM - 1);

  // Accumulator must hold DIM full-width squares without wrapping.
  generate
    if (ACC_W < 2 * WIDTH + $clog2(DIM)) begin : g_acc_w_check
      $error("kmeans_dist_unit: ACC_W too small for WIDTH/DIM");
    end
  endgenerate

  // Element counter and the mode held for the rest of the current vector
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_mode_hold;

  // Stage 1: magnitude plus tags
  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_s1_mag;
  logic               r_s1_first;
  logic               r_s1_last;
  logic               r_s1_mode;

  // Stage 2: per-element term plus tags
  logic               r_s2_valid;
  logic [2*WIDTH-1:0] r_s2_term;
  logic               r_s2_first;
  logic               r_s2_last;
  logic               r_s2_mode;

  // Stage 3: running sum and output registers
  logic [ACC_W-1:0]   r_acc;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_dist;
  logic               r_out_mode;

  logic               w_stall;
  logic               w_accept;
  logic               w_first;
  logic               w_last;
  logic               w_elem_mode;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_mag;
  logic [2*WIDTH-1:0] w_sq;
  logic [2*WIDTH-1:0] w_term;
  logic [ACC_W-1:0]   w_sum;

  assign w_stall     = r_out_valid & ~out_ready;
  assign in_ready    = ~w_stall;
  assign w_accept    = in_valid & ~w_stall;
  assign w_first     = (r_cnt == '0);
  assign w_last      = (r_cnt == c_cnt_last);
  // Mode is only honoured on element 0; later elements reuse the held value.
  assign w_elem_mode = w_first ? mode : r_mode_hold;

  // One extra bit exposes the borrow; the magnitude is always exact.
  assign w_diff   = {1'b0, in_x} - {1'b0, in_y};
  assign w_borrow = w_diff[WIDTH];
  assign w_mag    = w_borrow ? (in_y - in_x) : w_diff[WIDTH-1:0];

  assign w_sq     = {{WIDTH{1'b0}}, r_s1_mag} * {{WIDTH{1'b0}}, r_s1_mag};
  assign w_term   = r_s1_mode ? w_sq : {{WIDTH{1'b0}}, r_s1_mag};

  assign w_sum    = (r_s2_first ? '0 : r_acc) + ACC_W'(r_s2_term);

  assign out_valid = r_out_valid;
  assign out_dist  = r_out_dist;
  assign out_mode  = r_out_mode;

  // Element position within the vector and the latched vector mode
  always_ff @(posedge minus_clk or negedge minus_rst_n) begin
    if (!minus_rst_n) begin
      r_cnt       <= '0;
      r_mode_hold <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + c_cnt_w'(1);
      if (w_first) begin
        r_mode_hold <= mode;
      end
    end
  end

  // Stage 1: register |x-y| with first/last/mode tags
  always_ff @(posedge minus_clk or negedge minus_rst_n) begin
    if (!minus_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mag   <= w_mag;
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_s1_mode  <= w_elem_mode;
      end
    end
  end

  // Stage 2: register the L1 or squared-L2 term
  always_ff @(posedge minus_clk or negedge minus_rst_n) begin
    if (!minus_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_term  <= '0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_mode  <= 1'b0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_term  <= w_term;
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_mode  <= r_s1_mode;
      end
    end
  end

  // Stage 3: accumulate and publish the distance on the last element
  always_ff @(posedge minus_clk or negedge minus_rst_n) begin
    if (!minus_rst_n) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_dist  <= '0;
      r_out_mode  <= 1'b0;
    end else if (!w_stall) begin
      // Not stalled means any pending result is consumed at this edge.
      r_out_valid <= r_s2_valid & r_s2_last;
      if (r_s2_valid) begin
        r_acc <= w_sum;
        if (r_s2_last) begin
          r_out_dist <= w_sum;
          r_out_mode <= r_s2_mode;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kmeans_dist_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_kmeans_dist_unit
// Description : Self-checking bench for kmeans_dist_unit. Directed vectors
//               plus randomized traffic against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kmeans_dist_unit;

  localparam int WIDTH = 32;
  localparam int DIM   = 4;
  localparam int ACC_W = 66;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_dist;
  logic             out_mode;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [127:0]     exp_dist_q[$];
  logic             exp_mode_q[$];
  logic [127:0]     obs_dist_q[$];
  logic             obs_mode_q[$];
  logic [WIDTH-1:0] m_x[DIM];
  logic [WIDTH-1:0] m_y[DIM];
  int               m_cnt = 0;
  logic             m_mode = 1'b0;
  logic             prev_stall = 1'b0;
  logic [ACC_W-1:0] prev_dist = '0;
  logic             prev_mode = 1'b0;

  logic [WIDTH-1:0] vx[DIM];
  logic [WIDTH-1:0] vy[DIM];
  logic [WIDTH-1:0] vz[DIM];
  logic [127:0]     c_max_l2;
  logic             rand_done;

  always #5 clk = ~clk;

  kmeans_dist_unit #(.WIDTH(WIDTH), .DIM(DIM), .ACC_W(ACC_W)) dut (
    .minus_clk   (clk),
    .minus_rst_n (rst_n),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dist    (out_dist),
    .out_mode    (out_mode)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Distance of the collected vector computed directly from the definition
  function automatic logic [127:0] ref_dist(input logic sq);
    logic [127:0] s;
    logic [127:0] d;
    s = '0;
    for (int i = 0; i < DIM; i++) begin
      if (m_x[i] >= m_y[i]) d = 128'(m_x[i]) - 128'(m_y[i]);
      else                  d = 128'(m_y[i]) - 128'(m_x[i]);
      s = s + (sq ? d * d : d);
    end
    return s;
  endfunction

  // Monitor: observes transfers that happen at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = 0;
      exp_dist_q.delete();
      exp_mode_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("hold_dist", out_dist, prev_dist);
        check("hold_mode", out_mode, prev_mode);
      end
      prev_stall = out_valid && !out_ready;
      prev_dist  = out_dist;
      prev_mode  = out_mode;
      if (in_valid && in_ready) begin
        if (m_cnt == 0) m_mode = mode;
        m_x[m_cnt] = in_x;
        m_y[m_cnt] = in_y;
        m_cnt++;
        if (m_cnt == DIM) begin
          exp_dist_q.push_back(ref_dist(m_mode));
          exp_mode_q.push_back(m_mode);
          m_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        obs_dist_q.push_back(128'(out_dist));
        obs_mode_q.push_back(out_mode);
        if (exp_dist_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          check("out_dist", out_dist, exp_dist_q.pop_front());
          check("out_mode", out_mode, exp_mode_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    mode = m;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic send_vec(input logic [WIDTH-1:0] xs[DIM], input logic [WIDTH-1:0] ys[DIM],
                          input logic m);
    for (int i = 0; i < DIM; i++) send(xs[i], ys[i], m);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_dist_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", exp_dist_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_dist"},  out_dist,  '0);
    check({tag, "_out_mode"},  out_mode,  1'b0);
    check({tag, "_in_ready"},  in_ready,  1'b1);
  endtask

  task automatic clear_obs();
    obs_dist_q.delete();
    obs_mode_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    c_max_l2 = 128'h3_FFFF_FFF8_0000_0004;
    vx[0] = 50; vx[1] = 103; vx[2] = 86;  vx[3] = 0;
    vy[0] = 13; vy[1] = 86;  vy[2] = 100; vy[3] = 0;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // L1 with latency check
    clear_obs();
    out_ready = 1'b1;
    send_vec(vx, vy, 1'b0);
    in_valid = 1'b0;
    @(negedge clk); check("lat_k0", out_valid, 1'b0);
    @(negedge clk); check("lat_k1", out_valid, 1'b0);
    @(negedge clk); check("lat_k2", out_valid, 1'b1);
    check("t1_dist", out_dist, 68);
    check("t1_mode", out_mode, 1'b0);
    drain();

    // Squared L2 and the maximum-magnitude case
    clear_obs();
    send_vec(vx, vy, 1'b1);
    for (int i = 0; i < DIM; i++) begin vz[i] = '1; end
    for (int i = 0; i < DIM; i++) begin m_y[i] = m_y[i]; end
    begin
      logic [WIDTH-1:0] zeros[DIM];
      for (int i = 0; i < DIM; i++) zeros[i] = '0;
      send_vec(vz, zeros, 1'b1);
    end
    drain();
    check("t2_count", obs_dist_q.size(), 2);
    if (obs_dist_q.size() >= 2) begin
      check("t2_l2", obs_dist_q[0], 1854);
      check("t2_l2_mode", obs_mode_q[0], 1'b1);
      check("t2_max", obs_dist_q[1], c_max_l2);
    end

    // Back-to-back vectors, no bubble
    clear_obs();
    send_vec(vx, vy, 1'b0);
    send_vec(vx, vy, 1'b1);
    drain();
    check("t3_count", obs_dist_q.size(), 2);
    if (obs_dist_q.size() >= 2) begin
      check("t3_first", obs_dist_q[0], 68);
      check("t3_second", obs_dist_q[1], 1854);
    end

    // Output backpressure while the next vector streams
    clear_obs();
    out_ready = 1'b0;
    fork
      begin
        send_vec(vx, vy, 1'b0);
        send_vec(vx, vy, 1'b1);
        in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        check("t4_valid_seen", seen, 1'b1);
        repeat (5) begin
          check("t4_in_ready", in_ready, 1'b0);
          check("t4_hold68", out_dist, 68);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("t4_count", obs_dist_q.size(), 2);
    if (obs_dist_q.size() >= 2) begin
      check("t4_first", obs_dist_q[0], 68);
      check("t4_second", obs_dist_q[1], 1854);
    end

    // Reset in the middle of a vector
    clear_obs();
    send(vx[0], vy[0], 1'b1);
    send(vx[1], vy[1], 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      logic [WIDTH-1:0] a[DIM];
      logic [WIDTH-1:0] b[DIM];
      for (int i = 0; i < DIM; i++) begin a[i] = WIDTH'(i + 1); b[i] = '0; end
      send_vec(a, b, 1'b0);
    end
    drain();
    check("t5_count", obs_dist_q.size(), 1);
    if (obs_dist_q.size() >= 1) begin
      check("t5_dist", obs_dist_q[0], 10);
      check("t5_mode", obs_mode_q[0], 1'b0);
    end

    // Mode change mid-vector is ignored
    clear_obs();
    send(vx[0], vy[0], 1'b0);
    send(vx[1], vy[1], 1'b0);
    send(vx[2], vy[2], 1'b1);
    send(vx[3], vy[3], 1'b1);
    drain();
    check("t6_count", obs_dist_q.size(), 1);
    if (obs_dist_q.size() >= 1) begin
      check("t6_dist", obs_dist_q[0], 68);
      check("t6_mode", obs_mode_q[0], 1'b0);
    end

    // Randomized traffic: data, per-element mode, input bubbles, output stalls
    clear_obs();
    rand_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 40; v++) begin
          for (int e = 0; e < DIM; e++) begin
            logic [WIDTH-1:0] rx;
            logic [WIDTH-1:0] ry;
            rx = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 255));
            ry = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 255));
            send(rx, ry, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
              in_valid = 1'b0;
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
          end
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rand_count", obs_dist_q.size(), 40);
    check("rand_pending", exp_dist_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
